// File: rtl/seg7_scan_controller.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display.
// A shadow BCD value is committed to the displayed value only at frame boundaries.
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    update_pending,
  output logic [1:0]              dbg_state_o
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    wrap;
  logic                    commit;
  logic [3:0]              dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   supp;
  logic                    lead;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b0000001;
      4'd1:    encode = 7'b1001111;
      4'd2:    encode = 7'b0010010;
      4'd3:    encode = 7'b0000110;
      4'd4:    encode = 7'b1001100;
      4'd5:    encode = 7'b0100100;
      4'd6:    encode = 7'b0100000;
      4'd7:    encode = 7'b0001111;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0000100;
      default: encode = 7'b1111111;
    endcase
  endfunction

  always_comb begin : fsm_next
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load on the commit edge still lands in the shadow after the old shadow moves over.
  always_comb begin : value_next
    commit    = pending_q & (wrap | (state_q == S_IDLE));
    active_d  = commit ? shadow_q : active_q;
    shadow_d  = load ? bcd_in : shadow_q;
    pending_d = load | (pending_q & ~commit);
  end

  // Leading zeros are judged from the most significant digit down; digit 0 always shows.
  always_comb begin : lz_scan
    lead = 1'b1;
    supp = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig[i] = active_d[4*i +: 4];
    end
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead    = lead & (dig[i] == 4'd0);
      supp[i] = lz_suppress & lead;
    end
  end

  always_comb begin : out_next
    an_d         = '1;
    seg_d        = 7'b1111111;
    frame_tick_d = 1'b0;
    if (state_d == S_SHOW) begin
      an_d[idx_d]  = 1'b0;
      seg_d        = supp[idx_d] ? 7'b1111111 : encode(dig[idx_d]);
      frame_tick_d = (idx_d == LAST_IDX) && (cnt_d == SHOW_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'b1111111;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg            = seg_q;
  assign an             = an_q;
  assign frame_tick     = frame_tick_q;
  assign update_pending = pending_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: table of per-frame expected digit codes, scoreboard
// queue of expected {an, seg, frame_tick, update_pending} per cycle, hand-written corners.
module tb_seg7_scan_controller;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int DIGP  = RD + BC;
  localparam int FRAME = ND * DIGP;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] bcd_in;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        update_pending;
  logic [1:0]  dbg_state;

  seg7_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .load          (load),
    .bcd_in        (bcd_in),
    .lz_suppress   (lz_suppress),
    .seg           (seg),
    .an            (an),
    .frame_tick    (frame_tick),
    .update_pending(update_pending),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  // One record per displayed frame: lz setting and the code each digit must show {d3,d2,d1,d0}.
  typedef struct packed {
    logic            lz;
    logic [3:0][6:0] segs;
  } frame_rec_t;

  frame_rec_t  tbl [7];
  logic [12:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] exp_word(input int r, input int c, input logic up);
    int         p = c % DIGP;
    int         d = c / DIGP;
    logic [3:0] a = 4'hf;
    logic [6:0] s = 7'h7f;
    if (p >= BC) begin
      a[d] = 1'b0;
      s    = tbl[r].segs[d];
    end
    return {a, s, (c == FRAME - 1), up};
  endfunction

  task automatic compare_cycle(input string tag, input int c);
    logic [12:0] w;
    if (exp_q.size() == 0) begin
      check($sformatf("%s c%0d queue_empty", tag, c), 32'd0, 32'd1);
    end else begin
      w = exp_q.pop_front();
      check($sformatf("%s c%0d an", tag, c), {28'd0, an}, {28'd0, w[12:9]});
      check($sformatf("%s c%0d seg", tag, c), {25'd0, seg}, {25'd0, w[8:2]});
      check($sformatf("%s c%0d frame_tick", tag, c), {31'd0, frame_tick}, {31'd0, w[1]});
      check($sformatf("%s c%0d update_pending", tag, c), {31'd0, update_pending}, {31'd0, w[0]});
    end
  endtask

  task automatic check_dark(input string tag, input logic up);
    check({tag, " an"}, {28'd0, an}, 32'hf);
    check({tag, " seg"}, {25'd0, seg}, 32'h7f);
    check({tag, " frame_tick"}, {31'd0, frame_tick}, 32'd0);
    check({tag, " update_pending"}, {31'd0, update_pending}, {31'd0, up});
  endtask

  // Entered at cycle 0 (BLANK, digit 0) of a frame; leaves at cycle 0 of the next one.
  task automatic run_frame(input string tag, input int r, input logic up0,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb);
    for (int c = 0; c < FRAME; c++) begin
      exp_q.push_back(exp_word(r, c, up0 | (la >= 0 && c > la)));
    end
    for (int c = 0; c < FRAME; c++) begin
      compare_cycle(tag, c);
      if (c == 0) lz_suppress = tbl[r].lz;
      load   = (c == la) || (c == lb);
      bcd_in = (c == lb) ? vb : va;
      step();
    end
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1);
  end

  initial begin
    tbl[0] = {1'b0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}; // 0000
    tbl[1] = {1'b0, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}; // 1234
    tbl[2] = {1'b0, 7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}; // 2222
    tbl[3] = {1'b0, 7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001}; // 0070
    tbl[4] = {1'b0, 7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110}; // 3333
    tbl[5] = {1'b1, 7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}; // 0070, lz on
    tbl[6] = {1'b0, 7'b0000001, 7'b0000001, 7'b1111111, 7'b0100100}; // 00A5

    rst         = 1'b1;
    enable      = 1'b1;
    load        = 1'b0;
    bcd_in      = 16'h0000;
    lz_suppress = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_dark($sformatf("reset%0d", i), 1'b0);
    end
    rst = 1'b0;

    run_frame("f0_start",  0, 1'b0, 10, 16'h1234, -1, 16'h0000);
    run_frame("f1_1234",   1, 1'b0,  5, 16'h1111, 15, 16'h2222);
    run_frame("f2_2222",   2, 1'b0,  8, 16'h0070, 23, 16'h3333);
    run_frame("f3_0070",   3, 1'b1, -1, 16'h0000, -1, 16'h0000);
    run_frame("f4_3333",   4, 1'b0,  4, 16'h0070, -1, 16'h0000);
    run_frame("f5_lz",     5, 1'b0,  4, 16'h00A5, -1, 16'h0000);
    run_frame("f6_invalid", 6, 1'b0, -1, 16'h0000, -1, 16'h0000);

    // Drop enable on the first lit cycle of digit 2.
    for (int c = 0; c <= 14; c++) exp_q.push_back(exp_word(6, c, 1'b0));
    for (int c = 0; c <= 14; c++) begin
      compare_cycle("f7_drop", c);
      if (c == 14) enable = 1'b0;
      step();
    end
    check_dark("idle0", 1'b0);
    load   = 1'b1;
    bcd_in = 16'h0070;
    step();
    load = 1'b0;
    check_dark("idle_load", 1'b1);
    step();
    check_dark("idle_commit", 1'b0);
    enable = 1'b1;
    step();
    run_frame("f8_reenable", 3, 1'b0, -1, 16'h0000, -1, 16'h0000);

    // Reset while digit 0 is lit, with a pending value and a coincident load.
    for (int c = 0; c <= 3; c++) exp_q.push_back(exp_word(3, c, c > 2));
    for (int c = 0; c <= 3; c++) begin
      compare_cycle("f9_prerst", c);
      if (c == 2) begin
        load   = 1'b1;
        bcd_in = 16'h5555;
      end
      if (c == 3) begin
        rst    = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h9999;
      end
      step();
    end
    check_dark("midrst", 1'b0);
    rst  = 1'b0;
    load = 1'b0;
    run_frame("f10_postrst", 0, 1'b0, -1, 16'h0000, -1, 16'h0000);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
